// File: rtl/nrisc_flow_ctrl_if.sv
// nrisc_flow_ctrl_if: decoder-to-flow-unit control bundle and flow-unit status
interface nrisc_flow_ctrl_if #(
  parameter int TAM    = 16,
  parameter int NStack = 8,
  parameter int NFlags = 3
);
  localparam int DW = $clog2(NStack + 1);
  logic [2:0]        op;
  logic [TAM-1:0]    target;
  logic [NFlags-1:0] cond_mask;
  logic              cond_neg;
  logic [NFlags-1:0] flags_in;
  logic              irq_req;
  logic              ie_wr;
  logic              ie_val;
  logic [TAM-1:0]    pc;
  logic [NFlags-1:0] flags_out;
  logic              flags_restore;
  logic              irq_ack;
  logic              ie;
  logic [DW-1:0]     depth;
  logic              stack_full;
  logic              stack_empty;
  logic              stack_err;
  modport master (
    output op, target, cond_mask, cond_neg, flags_in, irq_req, ie_wr, ie_val,
    input  pc, flags_out, flags_restore, irq_ack, ie, depth, stack_full, stack_empty, stack_err
  );
  modport slave (
    input  op, target, cond_mask, cond_neg, flags_in, irq_req, ie_wr, ie_val,
    output pc, flags_out, flags_restore, irq_ack, ie, depth, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/nrisc_flow_ctrl.sv
// nrisc_flow_ctrl: PC, return/flag stack, conditional branch and vectored interrupt entry
module nrisc_flow_ctrl #(
  parameter int             TAM     = 16,
  parameter int             NStack  = 8,
  parameter int             NFlags  = 3,
  parameter logic [TAM-1:0] RST_VEC = '0,
  parameter logic [TAM-1:0] IRQ_VEC = TAM'(4)
) (
  input logic              clk,
  input logic              rst,
  nrisc_flow_ctrl_if.slave bus
);
  localparam int DW = $clog2(NStack + 1);
  localparam int AW = $clog2(NStack);
  typedef enum logic [2:0] {
    OP_INC, OP_HOLD, OP_JUMP, OP_BRANCH, OP_CALL, OP_RET, OP_RETI, OP_RSV
  } op_t;
  op_t               op;
  logic [TAM-1:0]    pc_q, pc_d, nxt, seq_pc, push_addr;
  logic [DW-1:0]     depth_q, depth_d;
  logic [AW-1:0]     top, wr_idx;
  logic [TAM-1:0]    stk_addr [NStack];
  logic [NFlags-1:0] stk_flg  [NStack];
  logic [NFlags-1:0] fo_q;
  logic              full, empty, taken, is_ret, irq_ok, do_call, do_pop, do_reti, push, err;
  logic              ie_q, ie_d, err_q, fr_q, ack_q;
  assign op     = op_t'(bus.op);
  assign full   = depth_q == DW'(NStack);
  assign empty  = depth_q == '0;
  assign top    = AW'(depth_q - 1'b1);
  assign wr_idx = AW'(depth_q);
  // next-state decode; interrupt entry borrows the address the sequential op would have produced
  always_comb begin
    nxt       = pc_q + 1'b1;
    taken     = (|(bus.flags_in & bus.cond_mask)) ^ bus.cond_neg;
    seq_pc    = op == OP_INC ? nxt : op == OP_JUMP ? bus.target :
                op == OP_BRANCH ? (taken ? bus.target : nxt) : pc_q;
    is_ret    = op == OP_RET || op == OP_RETI;
    irq_ok    = ie_q && bus.irq_req && op <= OP_BRANCH && !full;
    do_call   = op == OP_CALL && !full;
    do_pop    = is_ret && !empty;
    do_reti   = do_pop && op == OP_RETI;
    push      = irq_ok || do_call;
    err       = (op == OP_CALL && full) || (is_ret && empty);
    push_addr = irq_ok ? seq_pc : nxt;
    pc_d      = irq_ok ? IRQ_VEC : do_call ? bus.target : do_pop ? stk_addr[top] : seq_pc;
    depth_d   = push ? depth_q + 1'b1 : do_pop ? depth_q - 1'b1 : depth_q;
    ie_d      = bus.ie_wr ? bus.ie_val : irq_ok ? 1'b0 : do_reti ? 1'b1 : ie_q;
  end
  // control state; reset empties the stack by clearing depth
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RST_VEC;
      depth_q <= '0;
      ie_q    <= 1'b0;
      err_q   <= 1'b0;
      fo_q    <= '0;
      fr_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ie_q    <= ie_d;
      err_q   <= err_q | err;
      fo_q    <= do_reti ? stk_flg[top] : fo_q;
      fr_q    <= do_reti;
      ack_q   <= irq_ok;
    end
  end
  // stack storage needs no reset; entries above depth are never read
  always_ff @(posedge clk) begin
    if (push) begin
      stk_addr[wr_idx] <= push_addr;
      stk_flg[wr_idx]  <= bus.flags_in;
    end
  end
  assign bus.pc            = pc_q;
  assign bus.depth         = depth_q;
  assign bus.ie            = ie_q;
  assign bus.stack_err     = err_q;
  assign bus.flags_out     = fo_q;
  assign bus.flags_restore = fr_q;
  assign bus.irq_ack       = ack_q;
  assign bus.stack_full    = full;
  assign bus.stack_empty   = empty;
endmodule

// File: tb/tb_nrisc_flow_ctrl.sv
// tb_nrisc_flow_ctrl: directed vectors with a queued scoreboard checked by a per-cycle monitor
module tb_nrisc_flow_ctrl;
  localparam logic [2:0] INC = 3'd0, HOLD = 3'd1, JUMP = 3'd2, BRANCH = 3'd3,
                         CALL = 3'd4, RET = 3'd5, RETI = 3'd6, RSV = 3'd7;
  typedef struct {
    string       nm;
    logic [28:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   pass_cnt = 0;
  int   total = 0;
  exp_t q[$];
  nrisc_flow_ctrl_if #(.TAM(16), .NStack(8), .NFlags(3)) bus ();
  nrisc_flow_ctrl #(.TAM(16), .NStack(8), .NFlags(3), .RST_VEC(16'h0000), .IRQ_VEC(16'h0004)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // monitor: every cycle the DUT presents a new state, compare it to the oldest expectation
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      logic [28:0] act;
      e   = q.pop_front();
      act = {bus.pc, bus.depth, bus.stack_full, bus.stack_empty, bus.stack_err, bus.ie,
             bus.irq_ack, bus.flags_restore, bus.flags_out};
      total++;
      if (act === e.v) pass_cnt++;
      else $display("FAIL %s: got pc=%h d=%0d full=%b empty=%b err=%b ie=%b ack=%b fr=%b fo=%b, want pc=%h d=%0d full=%b empty=%b err=%b ie=%b ack=%b fr=%b fo=%b",
                    e.nm, act[28:13], act[12:9], act[8], act[7], act[6], act[5], act[4], act[3], act[2:0],
                    e.v[28:13], e.v[12:9], e.v[8], e.v[7], e.v[6], e.v[5], e.v[4], e.v[3], e.v[2:0]);
    end
  end
  task automatic step(input string nm, input logic [2:0] o, input logic [15:0] t,
                      input logic [15:0] epc, input logic [3:0] ed, input logic eerr,
                      input logic eie, input logic eack, input logic efr, input logic [2:0] efo);
    exp_t e;
    bus.op     = o;
    bus.target = t;
    e.nm = nm;
    e.v  = {epc, ed, ed == 4'd8, ed == 4'd0, eerr, eie, eack, efr, efo};
    q.push_back(e);
    @(negedge clk);
  endtask
  initial begin
    bus.op = INC; bus.target = 16'h1234; bus.cond_mask = '0; bus.cond_neg = 0;
    bus.flags_in = '0; bus.irq_req = 0; bus.ie_wr = 0; bus.ie_val = 0;
    @(negedge clk);
    step("reset", INC, 16'h1234, 16'h0000, 0, 0, 0, 0, 0, 3'b000);
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) step("inc", INC, 16'h1234, 16'(i), 0, 0, 0, 0, 0, 3'b000);
    step("jump_ffff", JUMP, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 0, 3'b000);
    step("inc_wrap", INC, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 3'b000);
    step("jump_10", JUMP, 16'h0010, 16'h0010, 0, 0, 0, 0, 0, 3'b000);
    bus.flags_in = 3'b101;
    step("call", CALL, 16'h0100, 16'h0100, 1, 0, 0, 0, 0, 3'b000);
    bus.flags_in = 3'b000;
    step("reti", RETI, 16'h0000, 16'h0011, 0, 0, 1, 0, 1, 3'b101);
    bus.ie_wr = 1; bus.ie_val = 0;
    step("restore_pulse_end", HOLD, 16'h0000, 16'h0011, 0, 0, 0, 0, 0, 3'b101);
    bus.ie_wr = 0;
    for (int i = 0; i < 8; i++)
      step("call_fill", CALL, 16'h0200 + 16'(i), 16'h0200 + 16'(i), 4'(i + 1), 0, 0, 0, 0, 3'b101);
    step("call_overflow", CALL, 16'h0300, 16'h0207, 8, 1, 0, 0, 0, 3'b101);
    bus.ie_wr = 1; bus.ie_val = 1;
    step("ie_set", HOLD, 16'h0000, 16'h0207, 8, 1, 1, 0, 0, 3'b101);
    bus.ie_wr = 0; bus.irq_req = 1;
    step("irq_full_blocked", HOLD, 16'h0000, 16'h0207, 8, 1, 1, 0, 0, 3'b101);
    bus.irq_req = 0; bus.ie_wr = 1; bus.ie_val = 0;
    step("ie_clr", HOLD, 16'h0000, 16'h0207, 8, 1, 0, 0, 0, 3'b101);
    bus.ie_wr = 0;
    for (int j = 0; j < 8; j++)
      step("ret_lifo", RET, 16'h0000, j < 7 ? 16'h0207 - 16'(j) : 16'h0012, 4'(7 - j), 1, 0, 0, 0, 3'b101);
    step("ret_underflow", RET, 16'h0000, 16'h0012, 0, 1, 0, 0, 0, 3'b101);
    step("reti_underflow", RETI, 16'h0000, 16'h0012, 0, 1, 0, 0, 0, 3'b101);
    bus.cond_mask = 3'b010; bus.flags_in = 3'b010;
    step("br_taken", BRANCH, 16'h0040, 16'h0040, 0, 1, 0, 0, 0, 3'b101);
    bus.flags_in = 3'b000;
    step("br_not_taken", BRANCH, 16'h0040, 16'h0041, 0, 1, 0, 0, 0, 3'b101);
    bus.cond_neg = 1;
    step("br_neg_taken", BRANCH, 16'h0040, 16'h0040, 0, 1, 0, 0, 0, 3'b101);
    bus.cond_neg = 0; bus.cond_mask = 3'b000; bus.flags_in = 3'b111;
    step("br_mask0", BRANCH, 16'h0040, 16'h0041, 0, 1, 0, 0, 0, 3'b101);
    step("jump_20", JUMP, 16'h0020, 16'h0020, 0, 1, 0, 0, 0, 3'b101);
    bus.ie_wr = 1; bus.ie_val = 1;
    step("ie_on", HOLD, 16'h0000, 16'h0020, 0, 1, 1, 0, 0, 3'b101);
    bus.ie_wr = 0; bus.irq_req = 1; bus.flags_in = 3'b110;
    step("irq_entry", JUMP, 16'h0080, 16'h0004, 1, 1, 0, 1, 0, 3'b101);
    bus.irq_req = 0;
    step("irq_ack_end", HOLD, 16'h0000, 16'h0004, 1, 1, 0, 0, 0, 3'b101);
    step("isr_inc", INC, 16'h0000, 16'h0005, 1, 1, 0, 0, 0, 3'b101);
    step("isr_reti", RETI, 16'h0000, 16'h0080, 0, 1, 1, 0, 1, 3'b110);
    step("after_reti", HOLD, 16'h0000, 16'h0080, 0, 1, 1, 0, 0, 3'b110);
    bus.irq_req = 1; bus.flags_in = 3'b000;
    step("irq_on_call", CALL, 16'h0500, 16'h0500, 1, 1, 1, 0, 0, 3'b110);
    bus.ie_wr = 1; bus.ie_val = 0;
    step("irq_iewr_wins", HOLD, 16'h0000, 16'h0004, 2, 1, 0, 1, 0, 3'b110);
    bus.ie_wr = 0;
    step("irq_ie0", HOLD, 16'h0000, 16'h0004, 2, 1, 0, 0, 0, 3'b110);
    bus.ie_wr = 1; bus.ie_val = 1;
    step("irq_old_ie", HOLD, 16'h0000, 16'h0004, 2, 1, 1, 0, 0, 3'b110);
    bus.ie_wr = 0;
    step("irq_first_ok", HOLD, 16'h0000, 16'h0004, 3, 1, 0, 1, 0, 3'b110);
    bus.irq_req = 0;
    step("hold", HOLD, 16'h0000, 16'h0004, 3, 1, 0, 0, 0, 3'b110);
    step("ret_a", RET, 16'h0000, 16'h0004, 2, 1, 0, 0, 0, 3'b110);
    step("ret_b", RET, 16'h0000, 16'h0500, 1, 1, 0, 0, 0, 3'b110);
    step("reti_c", RETI, 16'h0000, 16'h0081, 0, 1, 1, 0, 1, 3'b000);
    step("call_x", CALL, 16'h0600, 16'h0600, 1, 1, 1, 0, 0, 3'b000);
    step("call_y", CALL, 16'h0700, 16'h0700, 2, 1, 1, 0, 0, 3'b000);
    rst = 1'b0;
    step("mid_reset", INC, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 3'b000);
    rst = 1'b1;
    step("ret_after_reset", RET, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 3'b000);
    step("op_reserved", RSV, 16'h0123, 16'h0000, 0, 1, 0, 0, 0, 3'b000);
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/nrisc_flow_ctrl.md
Name: nrisc_flow_ctrl

Overview:
- Parametrised program-flow unit for the NRISC core. It replaces the fixed PC register and the fixed 8-deep PC/flag stack with a single block.
- It owns the PC and a return stack of configurable depth that holds the return address and the flags together.
- It adds conditional branch, vectored interrupt entry and return-from-interrupt with flag restore, plus full/empty/error reporting.
- It is driven each cycle by the core control decoder and feeds ProgADDR directly.

Parameters:
- TAM, 16, PC/address width in bits.
- NStack, 8, return stack depth in entries (>=2).
- NFlags, 3, width of the ULA flag vector saved on CALL and on interrupt entry.
- RST_VEC, 0, PC value loaded at reset.
- IRQ_VEC, 4, PC value loaded on interrupt entry.

Ports:
- clk  in  1  main clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- op  in  3  0 INC, 1 HOLD, 2 JUMP, 3 BRANCH, 4 CALL, 5 RET, 6 RETI, 7 reserved (acts as HOLD).
- target  in  TAM  destination for JUMP, BRANCH and CALL.
- cond_mask  in  NFlags  flag bits tested by BRANCH.
- cond_neg  in  1  inverts the BRANCH condition.
- flags_in  in  NFlags  current ULA flags; these are pushed.
- irq_req  in  1  level interrupt request.
- ie_wr  in  1  write strobe for the interrupt-enable register.
- ie_val  in  1  value written by ie_wr.
- pc  out  TAM  current program counter (registered).
- flags_out  out  NFlags  flags popped by RETI (registered).
- flags_restore  out  1  1-cycle pulse; flags_out is valid this cycle.
- irq_ack  out  1  1-cycle pulse on interrupt entry.
- ie  out  1  interrupt-enable register.
- depth  out  $clog2(NStack+1)  current stack occupancy.
- stack_full  out  1  depth==NStack.
- stack_empty  out  1  depth==0.
- stack_err  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (rst=0, async): pc=RST_VEC; depth=0; ie=0; stack_err=0; flags_out=0; flags_restore=0; irq_ack=0. Stack contents are don't-care. The first posedge after release executes op normally.
- Every op completes in one cycle; pc updates at the posedge that samples op.
- nxt = pc+1, computed mod 2^TAM (0xFFFF+1 wraps to 0 for TAM=16).
- INC: pc<=nxt.
- HOLD / 7: pc unchanged.
- JUMP: pc<=target.
- BRANCH: taken = (|(flags_in & cond_mask)) ^ cond_neg. If taken pc<=target, else pc<=nxt. With cond_mask=0 and cond_neg=0 the branch is never taken.
- CALL, not full: push {nxt, flags_in}; depth+1; pc<=target.
- CALL, full: no push, pc unchanged, stack_err<=1.
- RET, not empty: pop; pc<=saved address; depth-1. Saved flags are discarded.
- RETI, not empty: as RET, plus flags_out<=saved flags, flags_restore=1 for the next cycle, ie<=1.
- RET or RETI, empty: pc unchanged, stack_err<=1, no flag restore.
- Interrupt acceptance requires all of: ie=1, irq_req=1, op in {INC, HOLD, JUMP, BRANCH}, stack not full.
  - On acceptance: push {address op would have produced, flags_in}; pc<=IRQ_VEC; ie<=0; irq_ack=1 next cycle; depth+1.
  - Otherwise the request is deferred; nothing is latched and the level is re-sampled each cycle.
- ie_wr: ie<=ie_val. In the same cycle as interrupt acceptance or RETI, the ie_wr value wins. Acceptance uses the ie value held before the edge.
- Stack is LIFO, indexed by depth; no wrap. Over/underflow never corrupts depth or stored entries.
- stack_err clears only on reset.
- Reset asserted mid-sequence (e.g. inside a nested CALL) discards the whole stack immediately.

Test Plan:
- Reset with target=0x1234 and op=INC for 3 cycles -> pc 0, 1, 2, 3; depth=0; stack_empty=1. Preload pc=0xFFFF then INC -> pc=0x0000.
- pc=0x0010, CALL target=0x0100, flags_in=3'b101; then RETI -> after CALL pc=0x0100, depth=1. After RETI pc=0x0011, flags_out=3'b101, flags_restore high for exactly 1 cycle, ie=1.
- NStack=8: 9 CALLs, then 9 RETs -> 9th CALL holds pc and sets stack_err; depth stays 8. RETs return the 8 addresses in reverse order; 9th RET holds pc; stack_err stays 1.
- BRANCH target=0x0040, cond_mask=3'b010: flags_in=3'b010, cond_neg=0 -> pc=0x0040. flags_in=3'b000 -> pc=nxt. flags_in=3'b000, cond_neg=1 -> pc=0x0040.
- ie=1, pc=0x0020, op=JUMP target=0x0080, irq_req=1 -> pc=0x0004, irq_ack pulse, ie=0, pushed address 0x0080. A later RETI -> pc=0x0080, ie=1.
- irq_req=1 with op=CALL, or with stack full, or with ie=0 -> no entry and irq_ack=0. Entry occurs on the first cycle all conditions hold.
